// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, key-schedule FSM states, S-box and xtime helpers
package aes_pkg;
    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational single-round AES-128 key expansion
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] nxt
);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    assign {w0, w1, w2, w3} = key;
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign nxt = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 round-key generator with valid/ready output;
// optional round-key bank enabled by macro AES_KEY_STORE_EN
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_idx,
    output logic             done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
`endif
);
    state_t         state, state_nxt;
    logic [7:0]     rcon;
    logic [127:0]   rk_nxt;
    logic           xfer, last;
    assign xfer = rk_valid & rk_ready;
    assign last = rk_idx == 4'(NR);
    aes_key_step u_step (.key(rk_out), .rcon(rcon), .nxt(rk_nxt));
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    // next state: start only honoured in IDLE, final transfer ends the run
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start) state_nxt = EMIT;
        else if (state == EMIT && xfer && last) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end
    // datapath: key load, one expansion step per transfer, completion pulse
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_idx   <= '0;
            done     <= 1'b0;
            rcon     <= RCON_INIT;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                rk_out   <= key_in;
                rk_idx   <= '0;
                rk_valid <= 1'b1;
                busy     <= 1'b1;
                rcon     <= RCON_INIT;
            end else if (xfer && last) begin
                rk_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
            end else if (xfer) begin
                rk_out <= rk_nxt;
                rk_idx <= rk_idx + 4'd1;
                rcon   <= xtime(rcon);
            end else if (state == DONE) begin
                rcon <= RCON_INIT;
            end
        end
`ifdef AES_KEY_STORE_EN
    logic [KEY_W-1:0] bank [NR+1];
    // capture every transferred round key at its index
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) bank[i] <= '0;
        end else if (xfer) begin
            bank[rk_idx] <= rk_out;
        end
    assign rd_key = (rd_idx <= 4'(NR)) ? bank[rd_idx] : '0;
`endif
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed self-checking bench for aes_key_schedule (AES_KEY_STORE_EN aware)
module tb_aes_key_schedule;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b0;
    logic         busy, rk_valid, done;
    logic [127:0] key_in = '0, rk_out;
    logic [3:0]   rk_idx;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;
`endif
    int checks = 0, errors = 0;
    localparam logic [127:0] KA [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
`ifdef AES_KEY_STORE_EN
        , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic begin_run(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = '0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic check_key(input string tag, input int i);
        chk($sformatf("%s_idx%0d", tag, i), rk_idx, i);
        chk($sformatf("%s_key%0d", tag, i), rk_out, KA[i]);
        chk($sformatf("%s_valid%0d", tag, i), rk_valid, 1);
    endtask

    task automatic finish_chk(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_valid_low"}, rk_valid, 0);
        chk({tag, "_hold_key10"}, rk_out, KA[10]);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic run_a1(input string tag);
        rk_ready = 1'b1;
        begin_run(KA[0]);
        for (int i = 0; i <= 10; i++) begin
            check_key(tag, i);
            @(negedge clk);
        end
        finish_chk(tag);
    endtask

    initial begin
        int e, cyc;
        logic rdy;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_out", rk_out, 0);
        chk("rst_idx", rk_idx, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_a1("a1");
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd10; #1 chk("store_rd10", rd_key, KA[10]);
        rd_idx = 4'd0;  #1 chk("store_rd0", rd_key, KA[0]);
        rd_idx = 4'd5;  #1 chk("store_rd5", rd_key, KA[5]);
        rd_idx = 4'd12; #1 chk("store_rd12", rd_key, 0);
`endif
        begin_run(KA[0]);
        e = 0;
        cyc = 0;
        while (e <= 10 && cyc < 300) begin
            check_key("bp", e);
            rdy = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) e++;
        end
        chk("bp_all_transferred", e, 11);
        finish_chk("bp");
        rk_ready = 1'b1;
        begin_run(KA[0]);
        for (int i = 0; i <= 10; i++) begin
            check_key("ign", i);
            if (i == 4) begin
                start  = 1'b1;
                key_in = 128'hffeeddccbbaa99887766554433221100;
            end
            @(negedge clk);
            start  = 1'b0;
            key_in = '0;
        end
        finish_chk("ign");
        begin_run(KA[0]);
        for (int i = 0; i < 6; i++) begin
            check_key("abort", i);
            @(negedge clk);
        end
        chk("abort_at6", rk_idx, 6);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", rk_valid, 0);
        chk("abort_out", rk_out, 0);
        chk("abort_idx", rk_idx, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_still_idle", busy, 0);
        run_a1("rerun");
        begin_run('0);
        for (int i = 0; i <= 10; i++) begin
            chk($sformatf("zero_idx%0d", i), rk_idx, i);
            if (i == 0) chk("zero_key0", rk_out, 0);
            if (i == 1) chk("zero_key1", rk_out, 128'h62636363626363636263636362636363);
            if (i == 10) chk("zero_key10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
            @(negedge clk);
        end
        chk("zero_done", done, 1);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
